// File: rtl/base_decode_pipe_if.sv
// base_decode_pipe_if: valid/ready input beat and decoded output beat of base_decode_pipe.
interface base_decode_pipe_if #(
    parameter int enc_width = 1,
    parameter int dec_width = 2 ** enc_width
);
    logic i_v, i_r, i_en, o_v, o_r, o_err, o_err_sticky;
    logic [0:enc_width-1] i_d;
    logic [0:dec_width-1] o_d;
    modport master (output i_v, i_en, i_d, o_r, input i_r, o_v, o_d, o_err, o_err_sticky);
    modport slave (input i_v, i_en, i_d, o_r, output i_r, o_v, o_d, o_err, o_err_sticky);
endinterface

// File: rtl/base_decode_pipe.sv
// base_decode_pipe: registered one-hot/thermometer decoder with a 2-entry skid buffer
// so that input ready comes straight from a flop.
module base_decode_pipe #(
    parameter int enc_width = 1,
    parameter int dec_width = 2 ** enc_width,
    parameter int mode = 0
) (
    input logic clk,
    input logic reset,
    base_decode_pipe_if.slave bus
);
    if (dec_width < 1 || dec_width > 2 ** enc_width) begin : g_bad_cfg
        $error("base_decode_pipe: dec_width must lie in 1..2**enc_width");
    end
    logic [31:0] du;
    logic [0:dec_width-1] dec, skid_d;
    logic err, skid_err, skid_v, acc, load_out, skid_v_n;
    always_comb begin
        du = 32'(bus.i_d);
        err = bus.i_en && du >= 32'(dec_width);
        dec = '0;
        for (int j = 0; j < dec_width; j++)
            dec[j] = bus.i_en && (mode != 0 ? 32'(j) <= du : 32'(j) == du);
    end
    assign acc = bus.i_v && bus.i_r;
    // The output register may take new data whenever it is empty or being drained.
    assign load_out = !bus.o_v || bus.o_r;
    assign skid_v_n = bus.o_v && !bus.o_r && (skid_v || acc);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.o_v <= 1'b0;
            bus.o_d <= '0;
            bus.o_err <= 1'b0;
            bus.o_err_sticky <= 1'b0;
            bus.i_r <= 1'b0;
            skid_v <= 1'b0;
            skid_d <= '0;
            skid_err <= 1'b0;
        end else begin
            bus.i_r <= !skid_v_n;
            skid_v <= skid_v_n;
            if (acc && err) bus.o_err_sticky <= 1'b1;
            if (load_out) begin
                bus.o_v <= skid_v || acc;
                if (skid_v) begin
                    bus.o_d <= skid_d;
                    bus.o_err <= skid_err;
                end else if (acc) begin
                    bus.o_d <= dec;
                    bus.o_err <= err;
                end
            end else if (acc) begin
                skid_d <= dec;
                skid_err <= err;
            end
        end
endmodule

// File: doc/base_decode_pipe.md
# base_decode_pipe

Pipelined, flow-controlled successor to the combinational binary-to-one-hot decoder. Accepts an encoded value with enable on a valid/ready input port and presents it registered, decoded, on a valid/ready output port. Decode is one-hot or thermometer, selected by parameter, and the block flags codes outside the decoded range. A 2-entry skid stage keeps the input ready registered, so the block can sit between timing-critical pipeline stages (tag/select fan-out, lane enables) without a combinational ready path.

## Interface
- enc_width, default 1: width of encoded input.
- dec_width, default 2**enc_width: width of decoded output.
  - Legal range 1 ≤ dec_width ≤ 2**enc_width.
  - Values outside this range are a configuration error and must be flagged at elaboration.
- mode, default 0: 0 = one-hot decode, 1 = thermometer decode.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input valid.
- i_r  output  1  input ready; registered, no combinational path from o_r.
- i_en  input  1  decode enable carried with the beat.
- i_d  input  [0:enc_width-1]  encoded value, unsigned.
- o_v  output  1  output valid.
- o_r  input  1  output ready.
- o_d  output  [0:dec_width-1]  decoded value.
- o_err  output  1  range error for the beat currently on o_d.
- o_err_sticky  output  1  set on any accepted out-of-range beat; cleared only by reset.

## Operation
- Input accept occurs when i_v & i_r. Output transfer occurs when o_v & o_r.
- Each accepted beat is decoded in full in the accept cycle, then stored. Payload per entry is {o_d, o_err}.
- Decode of beat (en, d), with j in 0..dec_width-1:
  - en=0: o_d all zero, err=0.
  - mode 0: o_d[j] = en & (d == j).
  - mode 1: o_d[j] = en & (j ≤ d).
  - err = en & (d ≥ dec_width). This can only occur when dec_width < 2**enc_width.
    - mode 0: o_d is all zero.
    - mode 1: o_d is all ones.
- Storage is an output register plus one skid register. The state is the pair (o_v, skid_v):
  - EMPTY (0,0):
    - accept → FULL1, beat loaded into output register.
  - FULL1 (1,0):
    - accept & transfer → FULL1; output register reloaded with new beat.
    - accept & ~transfer → FULL2; new beat loaded into skid register.
    - ~accept & transfer → EMPTY.
    - otherwise hold.
  - FULL2 (1,1):
    - transfer → FULL1; skid contents move to output register.
    - otherwise hold.
    - No accept is possible in FULL2 (i_r=0).
- i_r = ~skid_v & ~reset.
- Order is strictly preserved; no beat is dropped or duplicated.
- o_d and o_err are held stable while o_v=1 and o_r=0.
- o_err_sticky sets on accept of any beat with err=1 and stays set until reset.
- i_d and i_en are ignored when i_v=0 or i_r=0.

## Timing
- Reset values, applied asynchronously on assertion:
  - o_v=0, o_d=0, o_err=0, o_err_sticky=0.
  - skid_v=0, skid payload=0.
  - i_r=0 while reset is high.
- i_r=1 from the first clock edge after reset deasserts.
- Latency: beat accepted at edge N appears with o_v=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained while o_r=1.
- o_r deasserted for a single cycle while i_v=1 continuous:
  - one beat lands in the skid register;
  - i_r drops the following cycle;
  - i_r recovers one cycle after o_r returns.
- Simultaneous accept and transfer in FULL1 leaves the state unchanged (FULL1), with the payload replaced.
- Reset mid-operation discards both entries. No output transfer completes in the cycle reset is asserted.
- o_v, o_d, o_err and i_r are driven directly from flops, with no combinational input-to-output path.

## Test plan
- Reset then stream: enc_width=3, mode=0, o_r=1; send i_d=0..7 with i_en=1.
  - Required: o_d = 1000_0000 … 0000_0001 one cycle after each accept, o_err=0, one beat per cycle.
- Thermometer and enable: mode=1, enc_width=3; send i_d=5 with i_en=1, then i_d=5 with i_en=0.
  - Required: o_d = 1111_1100, then 0000_0000.
- Range error: enc_width=3, dec_width=6, mode 0 and mode 1; send i_d=6, then i_d=2.
  - Required for i_d=6: o_err=1; o_d = all zero (mode 0) or all ones (mode 1).
  - Required for i_d=2: o_err=0.
  - o_err_sticky remains 1 through both beats and after.
- Backpressure/skid: continuous i_v with incrementing i_d; drop o_r for 3 cycles.
  - Required: i_r=0 after one skid beat is captured.
  - Output sequence is contiguous with no loss or repeat.
  - o_d is stable while stalled.
- Random stress: random i_v/o_r at 50%, 10k beats.
  - Required: scoreboard matches the reference decode in order.
  - i_r never depends combinationally on o_r.
- Reset mid-stream in FULL2: assert reset asynchronously between edges.
  - Required: o_v=0, o_err_sticky=0 and i_r=0 immediately.
  - First post-reset beat decodes correctly with latency 1.
